// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
// The state encodings are visible on the debug/CSR state output, so they are fixed.
package pll_reset_sequencer_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      PLL_RESET = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Width needed to hold 0..n-1, never narrower than one bit.
   function automatic int width_for(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for level signals crossing into the local clock domain.
// Both stages clear to 0 on the asynchronous active-high reset.
module sync_2ff #(
   parameter int W = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer and lock monitor on refclk: holds system reset until lock is stable.
// Optional RUN-state dip filter enabled by defining PLL_RESET_SEQUENCER_LOSS_FILTER_EN.
module pll_reset_sequencer
   import pll_reset_sequencer_pkg::*;
#(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 3,
   parameter int CNT_W         = 8,
   parameter int LOSS_FILTER   = 4
) (
   input  logic               refclk,
   input  logic               rst,
   input  logic               locked,
   input  logic               restart,
   output logic               pll_rst,
   output logic               sys_rst,
   output logic               ready,
   output logic               fail,
   output logic [STATE_W-1:0] state,
   output logic [CNT_W-1:0]   lock_loss_cnt
);

   localparam int TMR_W = width_for(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
   localparam int RTY_W = width_for(MAX_RETRIES + 1);

   logic locked_s;

   sync_2ff #(.W(1)) u_lock_sync (
      .clk_i (refclk),
      .rst_i (rst),
      .d_i   (locked),
      .q_o   (locked_s)
   );

   state_e             state_q, state_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [RTY_W-1:0]   retry_q, retry_d;
   logic [RTY_W-1:0]   retry_inc;
   logic [CNT_W-1:0]   loss_cnt_q, loss_cnt_d;
   logic               pll_rst_q, sys_rst_q, ready_q, fail_q;
   logic               lock_lost;

`ifdef PLL_RESET_SEQUENCER_LOSS_FILTER_EN
   localparam int DIP_W = width_for(LOSS_FILTER);

   logic [DIP_W-1:0] dip_q, dip_d;

   // A loss is declared on the LOSS_FILTER-th consecutive low cycle seen in RUN.
   assign lock_lost = !locked_s && (dip_q == DIP_W'(LOSS_FILTER - 1));

   always_comb begin
      dip_d = '0;
      if (state_q == RUN && !locked_s && !lock_lost && !restart) begin
         dip_d = dip_q + DIP_W'(1);
      end
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         dip_q <= '0;
      end else begin
         dip_q <= dip_d;
      end
   end
`else
   localparam int unused_loss_filter = LOSS_FILTER;

   assign lock_lost = !locked_s;
`endif

   assign retry_inc = retry_q + RTY_W'(1);

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      retry_d    = retry_q;
      loss_cnt_d = loss_cnt_q;
      if (restart) begin
         state_d = PLL_RESET;
         timer_d = '0;
         retry_d = '0;
      end else begin
         case (state_q)
            PLL_RESET: begin
               if (timer_q == TMR_W'(RST_CYCLES - 1)) begin
                  state_d = WAIT_LOCK;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
            WAIT_LOCK: begin
               if (locked_s) begin
                  state_d = STABLE;
                  timer_d = '0;
               end else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
                  timer_d = '0;
                  retry_d = retry_inc;
                  state_d = (retry_inc == RTY_W'(MAX_RETRIES)) ? FAIL : PLL_RESET;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
            STABLE: begin
               // A dip here only restarts the lock wait; it is not a failed attempt.
               if (!locked_s) begin
                  state_d = WAIT_LOCK;
                  timer_d = '0;
               end else if (timer_q == TMR_W'(STABLE_CYCLES - 1)) begin
                  state_d = RUN;
                  timer_d = '0;
                  retry_d = '0;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
            RUN: begin
               if (lock_lost) begin
                  state_d = PLL_RESET;
                  timer_d = '0;
                  if (loss_cnt_q != {CNT_W{1'b1}}) begin
                     loss_cnt_d = loss_cnt_q + CNT_W'(1);
                  end
               end
            end
            FAIL: begin
               state_d = FAIL;
            end
            default: begin
               state_d = PLL_RESET;
               timer_d = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they move on the same edge as state.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q    <= PLL_RESET;
         timer_q    <= '0;
         retry_q    <= '0;
         loss_cnt_q <= '0;
         pll_rst_q  <= 1'b1;
         sys_rst_q  <= 1'b1;
         ready_q    <= 1'b0;
         fail_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         retry_q    <= retry_d;
         loss_cnt_q <= loss_cnt_d;
         pll_rst_q  <= (state_d == PLL_RESET) || (state_d == FAIL);
         sys_rst_q  <= (state_d != RUN);
         ready_q    <= (state_d == RUN);
         fail_q     <= (state_d == FAIL);
      end
   end

   assign pll_rst       = pll_rst_q;
   assign sys_rst       = sys_rst_q;
   assign ready         = ready_q;
   assign fail          = fail_q;
   assign state         = state_q;
   assign lock_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: vector table for bring-up/timeout/fail,
// hand-written sequences for lock loss, instability, priority, async reset and dip filter.
module tb_pll_reset_sequencer;

   logic       refclk;
   logic       rst;
   logic       locked;
   logic       restart;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fail;
   logic [2:0] state;
   logic [7:0] lock_loss_cnt;

   int total = 0;
   int bad   = 0;

   pll_reset_sequencer #(
      .RST_CYCLES    (4),
      .LOCK_TIMEOUT  (20),
      .STABLE_CYCLES (8),
      .MAX_RETRIES   (2),
      .CNT_W         (8),
      .LOSS_FILTER   (4)
   ) dut (
      .refclk        (refclk),
      .rst           (rst),
      .locked        (locked),
      .restart       (restart),
      .pll_rst       (pll_rst),
      .sys_rst       (sys_rst),
      .ready         (ready),
      .fail          (fail),
      .state         (state),
      .lock_loss_cnt (lock_loss_cnt)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   typedef struct {
      logic       lk;
      logic       rs;
      int         n;
      logic       pll;
      logic       sys;
      logic       rdy;
      logic       fl;
      logic [2:0] st;
      logic [7:0] cnt;
   } vec_t;

   vec_t vecs [17];

   task automatic step(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input logic p, input logic s, input logic r,
                            input logic f, input logic [2:0] st, input logic [7:0] c);
      check({name, ".pll_rst"}, 32'(pll_rst), 32'(p));
      check({name, ".sys_rst"}, 32'(sys_rst), 32'(s));
      check({name, ".ready"}, 32'(ready), 32'(r));
      check({name, ".fail"}, 32'(fail), 32'(f));
      check({name, ".state"}, 32'(state), 32'(st));
      check({name, ".cnt"}, 32'(lock_loss_cnt), 32'(c));
   endtask

   task automatic wait_state(input logic [2:0] tgt, input int budget, input string name);
      int n;
      n = 0;
      while (state !== tgt && n < budget) begin
         step(1);
         n++;
      end
      check(name, 32'(state), 32'(tgt));
   endtask

   // One-cycle dip in RUN, then wait for the full re-sequence back to RUN.
   task automatic dip_and_recover();
      locked = 1'b0;
      step(1);
      locked = 1'b1;
      step(2);
      wait_state(3'd3, 40, "recover");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //             lk    rs    n   pll   sys   rdy   fl    st    cnt
      vecs[0]  = '{1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};
      vecs[1]  = '{1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd0};
      vecs[2]  = '{1'b0, 1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd0};
      vecs[3]  = '{1'b1, 1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'd0};
      vecs[4]  = '{1'b1, 1'b0, 7, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'd0};
      vecs[5]  = '{1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 8'd0};
      vecs[6]  = '{1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};
      vecs[7]  = '{1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};
      vecs[8]  = '{1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd0};
      vecs[9]  = '{1'b0, 1'b0, 19, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd0};
      vecs[10] = '{1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};
      vecs[11] = '{1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};
      vecs[12] = '{1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd0};
      vecs[13] = '{1'b0, 1'b0, 19, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd0};
      vecs[14] = '{1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 8'd0};
      vecs[15] = '{1'b0, 1'b0, 5, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 8'd0};
      vecs[16] = '{1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};

      rst     = 1'b1;
      locked  = 1'b0;
      restart = 1'b0;
      step(3);
      check_all("reset", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
      rst = 1'b0;

      // Bring-up, then two timeouts into FAIL and a restart out of it.
      for (int i = 0; i < 17; i++) begin
         locked  = vecs[i].lk;
         restart = vecs[i].rs;
         step(vecs[i].n);
         check_all($sformatf("vec%0d", i), vecs[i].pll, vecs[i].sys, vecs[i].rdy,
                   vecs[i].fl, vecs[i].st, vecs[i].cnt);
      end
      restart = 1'b0;

      locked = 1'b1;
      wait_state(3'd3, 40, "bringup2");

      // Single lock loss: sys_rst rises on the third edge after locked falls.
      locked = 1'b0;
      step(1);
      locked = 1'b1;
      step(1);
      check_all("loss_e2", 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 8'd0);
      step(1);
      check_all("loss_e3", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd1);
      step(12);
      check("loss_e15.state", 32'(state), 32'd2);
      step(1);
      check_all("loss_e16", 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 8'd1);

      // Instability: dip observed at stable count 5 returns to WAIT_LOCK.
      restart = 1'b1;
      step(1);
      restart = 1'b0;
      check_all("inst_restart", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd1);
      step(4);
      check("inst_wait.state", 32'(state), 32'd1);
      step(1);
      check("inst_stable.state", 32'(state), 32'd2);
      step(3);
      locked = 1'b0;
      step(1);
      locked = 1'b1;
      step(1);
      check("inst_c5.state", 32'(state), 32'd2);
      step(1);
      check_all("inst_back", 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd1);
      step(1);
      check("inst_restable.state", 32'(state), 32'd2);
      step(7);
      check_all("inst_pre_run", 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'd1);
      step(1);
      check_all("inst_run", 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 8'd1);

      // restart coinciding with a RUN lock loss wins and is not counted.
      locked = 1'b0;
      step(2);
      check("prio_pre.ready", 32'(ready), 32'd1);
      restart = 1'b1;
      step(1);
      restart = 1'b0;
      locked  = 1'b1;
      check_all("prio", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd1);
      step(1);
      check("prio_after.cnt", 32'(lock_loss_cnt), 32'd1);
      wait_state(3'd3, 40, "prio_rerun");

      // Saturation of the loss counter.
      for (int i = 2; i <= 255; i++) begin
         dip_and_recover();
      end
      check("sat255.cnt", 32'(lock_loss_cnt), 32'd255);
      dip_and_recover();
      check("sat256.cnt", 32'(lock_loss_cnt), 32'd255);

      // Asynchronous reset in STABLE, checked before any further edge.
      restart = 1'b1;
      step(1);
      restart = 1'b0;
      wait_state(3'd2, 20, "to_stable");
      step(2);
      #2 rst = 1'b1;
      #1;
      check_all("async_rst", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
      step(1);
      rst = 1'b0;

`ifdef PLL_RESET_SEQUENCER_LOSS_FILTER_EN
      wait_state(3'd3, 40, "filt_run");
      locked = 1'b0;
      step(3);
      locked = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(1);
         check($sformatf("filt_dip3_%0d.ready", i), 32'(ready), 32'd1);
      end
      locked = 1'b0;
      step(4);
      locked = 1'b1;
      step(1);
      check_all("filt_e5", 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 8'd0);
      step(1);
      check_all("filt_e6", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd1);
`else
      wait_state(3'd3, 40, "post_rst_run");
      check("post_rst_run.cnt", 32'(lock_loss_cnt), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
